// File: rtl/rf_config_controller.sv
// RF module configuration command controller: collects C0..C4 commands, updates parameters, returns responses.
// Optional macro RF_CFG_SAVE_EN adds a saved-parameter shadow bank (written by C0, restored by C4).
module rf_config_controller #(
   parameter logic [7:0]  DEFAULT_ADDH   = 8'h00,
   parameter logic [7:0]  DEFAULT_ADDL   = 8'h00,
   parameter logic [7:0]  DEFAULT_SPED   = 8'h1A,
   parameter logic [7:0]  DEFAULT_CHAN   = 8'h17,
   parameter logic [7:0]  DEFAULT_OPTION = 8'h44,
   parameter logic [7:0]  VERSION_ID     = 8'h32,
   parameter int unsigned BYTE_TIMEOUT   = 15000,
   parameter int unsigned RESET_HOLD     = 10000
) (
   input  logic       internal_clk,
   input  logic       rst_n,
   input  logic       sleep_mode,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   output logic       AUX_config_ctrl,
   output logic [7:0] addh,
   output logic [7:0] addl,
   output logic [7:0] sped,
   output logic [7:0] chan,
   output logic [7:0] option
);

   localparam int unsigned       GAP_W     = $clog2(BYTE_TIMEOUT + 1);
   localparam int unsigned       HOLD_W    = $clog2(RESET_HOLD + 1);
   localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(BYTE_TIMEOUT);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   localparam logic [7:0] CMD_SET_SAVE = 8'hC0;
   localparam logic [7:0] CMD_READ     = 8'hC1;
   localparam logic [7:0] CMD_SET_TEMP = 8'hC2;
   localparam logic [7:0] CMD_VERSION  = 8'hC3;
   localparam logic [7:0] CMD_RESET    = 8'hC4;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      EXEC,
      RESPOND,
      HOLD
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [7:0]          cmd_buf [0:5];
   logic [2:0]          byte_cnt;
   logic [2:0]          resp_idx;
   logic [2:0]          resp_last;
   logic [GAP_W-1:0]    gap_cnt;
   logic [HOLD_W-1:0]   hold_cnt;

   logic                first_ok;
   logic                long_cmd;
   logic                timeout;
   logic                echo_bad;
   logic                accept;
   logic                discard;
   logic                handshake;

`ifdef RF_CFG_SAVE_EN
   logic [7:0]          save_bank [0:4];
`endif

   always_comb begin
      first_ok  = (rx_data >= CMD_SET_SAVE) && (rx_data <= CMD_RESET);
      long_cmd  = (cmd_buf[0] == CMD_SET_SAVE) || (cmd_buf[0] == CMD_SET_TEMP);
      timeout   = (gap_cnt >= GAP_LIMIT);
      echo_bad  = !long_cmd && (rx_data != cmd_buf[0]);
      handshake = tx_valid && tx_ready;
      accept    = 1'b0;
      discard   = 1'b0;
      state_d   = state_q;
      case (state_q)
         IDLE: begin
            if (rx_valid && sleep_mode && first_ok) begin
               accept  = 1'b1;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (!sleep_mode || timeout || (rx_valid && echo_bad)) begin
               discard = 1'b1;
               state_d = IDLE;
            end else if (rx_valid) begin
               accept = 1'b1;
               if (byte_cnt == (long_cmd ? 3'd5 : 3'd2)) begin
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            if (cmd_buf[0] == CMD_RESET) begin
               state_d = HOLD;
            end else if (cmd_buf[0] >= CMD_SET_SAVE && cmd_buf[0] <= CMD_VERSION) begin
               state_d = RESPOND;
            end else begin
               state_d = IDLE;
            end
         end
         RESPOND: begin
            if (handshake && (resp_idx == resp_last)) begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // AUX is high exactly when the controller will be idle in the coming cycle.
   always_ff @(posedge internal_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         AUX_config_ctrl <= 1'b1;
      end else begin
         state_q         <= state_d;
         AUX_config_ctrl <= (state_d == IDLE);
      end
   end

   always_ff @(posedge internal_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 6; i++) begin
            cmd_buf[i] <= '0;
         end
         byte_cnt  <= '0;
         resp_idx  <= '0;
         resp_last <= '0;
         gap_cnt   <= '0;
         hold_cnt  <= '0;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         addh      <= DEFAULT_ADDH;
         addl      <= DEFAULT_ADDL;
         sped      <= DEFAULT_SPED;
         chan      <= DEFAULT_CHAN;
         option    <= DEFAULT_OPTION;
`ifdef RF_CFG_SAVE_EN
         save_bank[0] <= DEFAULT_ADDH;
         save_bank[1] <= DEFAULT_ADDL;
         save_bank[2] <= DEFAULT_SPED;
         save_bank[3] <= DEFAULT_CHAN;
         save_bank[4] <= DEFAULT_OPTION;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cmd_buf[0] <= rx_data;
                  byte_cnt   <= 3'd1;
                  gap_cnt    <= '0;
               end
            end
            COLLECT: begin
               if (discard) begin
                  byte_cnt <= '0;
                  gap_cnt  <= '0;
               end else if (accept) begin
                  cmd_buf[byte_cnt] <= rx_data;
                  byte_cnt          <= byte_cnt + 3'd1;
                  gap_cnt           <= '0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            EXEC: begin
               byte_cnt <= '0;
               gap_cnt  <= '0;
               resp_idx <= '0;
               hold_cnt <= '0;
               case (cmd_buf[0])
                  CMD_SET_SAVE, CMD_SET_TEMP: begin
                     addh      <= cmd_buf[1];
                     addl      <= cmd_buf[2];
                     sped      <= cmd_buf[3];
                     chan      <= cmd_buf[4];
                     option    <= cmd_buf[5];
`ifdef RF_CFG_SAVE_EN
                     if (cmd_buf[0] == CMD_SET_SAVE) begin
                        for (int unsigned i = 0; i < 5; i++) begin
                           save_bank[i] <= cmd_buf[i+1];
                        end
                     end
`endif
                     resp_last <= 3'd5;
                     tx_valid  <= 1'b1;
                     tx_data   <= cmd_buf[0];
                  end
                  CMD_READ: begin
                     // Response is staged in the command buffer so RESPOND only walks an index.
                     cmd_buf[0] <= CMD_SET_SAVE;
                     cmd_buf[1] <= addh;
                     cmd_buf[2] <= addl;
                     cmd_buf[3] <= sped;
                     cmd_buf[4] <= chan;
                     cmd_buf[5] <= option;
                     resp_last  <= 3'd5;
                     tx_valid   <= 1'b1;
                     tx_data    <= CMD_SET_SAVE;
                  end
                  CMD_VERSION: begin
                     cmd_buf[1] <= VERSION_ID;
                     cmd_buf[2] <= 8'h00;
                     cmd_buf[3] <= 8'h14;
                     resp_last  <= 3'd3;
                     tx_valid   <= 1'b1;
                     tx_data    <= CMD_VERSION;
                  end
                  CMD_RESET: begin
`ifdef RF_CFG_SAVE_EN
                     addh   <= save_bank[0];
                     addl   <= save_bank[1];
                     sped   <= save_bank[2];
                     chan   <= save_bank[3];
                     option <= save_bank[4];
`else
                     addh   <= DEFAULT_ADDH;
                     addl   <= DEFAULT_ADDL;
                     sped   <= DEFAULT_SPED;
                     chan   <= DEFAULT_CHAN;
                     option <= DEFAULT_OPTION;
`endif
                  end
                  default: begin
                  end
               endcase
            end
            RESPOND: begin
               if (handshake) begin
                  if (resp_idx == resp_last) begin
                     tx_valid <= 1'b0;
                     tx_data  <= '0;
                  end else begin
                     resp_idx <= resp_idx + 3'd1;
                     tx_data  <= cmd_buf[resp_idx + 3'd1];
                  end
               end
            end
            HOLD: begin
               hold_cnt <= hold_cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_config_controller.sv
// Randomized scoreboard bench for rf_config_controller; expected responses come from a command-level model.
module tb_rf_config_controller;

   localparam int unsigned TO   = 40;
   localparam int unsigned HOLD = 30;

   logic       internal_clk = 1'b0;
   logic       rst_n        = 1'b0;
   logic       sleep_mode   = 1'b1;
   logic       rx_valid     = 1'b0;
   logic [7:0] rx_data      = '0;
   logic       tx_ready     = 1'b0;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       AUX_config_ctrl;
   logic [7:0] addh, addl, sped, chan, option;

   rf_config_controller #(
      .BYTE_TIMEOUT(TO),
      .RESET_HOLD  (HOLD)
   ) dut (
      .internal_clk   (internal_clk),
      .rst_n          (rst_n),
      .sleep_mode     (sleep_mode),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_ready       (tx_ready),
      .AUX_config_ctrl(AUX_config_ctrl),
      .addh           (addh),
      .addl           (addl),
      .sped           (sped),
      .chan           (chan),
      .option         (option)
   );

   always #5 internal_clk = ~internal_clk;

   logic [7:0] DEF    [5] = '{8'h00, 8'h00, 8'h1A, 8'h17, 8'h44};
   logic [7:0] m_par  [5];
   logic [7:0] m_save [5];
   logic [7:0] exp_q  [$];
   int         n_cmp      = 0;
   int         n_bad      = 0;
   int         ready_mode = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // tx_ready pattern: 0 always ready, 1 toggling, 2 random, 3 stalled.
   initial forever begin
      @(posedge internal_clk);
      #1;
      case (ready_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         2:       tx_ready = 1'($urandom_range(0, 1));
         default: tx_ready = 1'b0;
      endcase
   end

   logic       hold_pend = 1'b0;
   logic [7:0] hold_data = '0;

   always @(negedge internal_clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("tx_hold_valid", tx_valid, 1);
            check("tx_hold_data", tx_data, hold_data);
         end
         hold_pend = tx_valid && !tx_ready;
         hold_data = tx_data;
         if (tx_valid) begin
            check("aux_low_during_tx", AUX_config_ctrl, 0);
            if (tx_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL tx_unexpected: got byte %0h expected no response", tx_data);
               end else begin
                  check("tx_byte", tx_data, exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge internal_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic check_params();
      check("addh", addh, m_par[0]);
      check("addl", addl, m_par[1]);
      check("sped", sped, m_par[2]);
      check("chan", chan, m_par[3]);
      check("option", option, m_par[4]);
   endtask

   task automatic wait_aux_high(input string name, input int budget);
      int n = 0;
      while (AUX_config_ctrl !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(name, AUX_config_ctrl, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      m_par  = DEF;
      m_save = DEF;
      exp_q.delete();
      tick();
   endtask

   // Model applies the whole command at issue time; the DUT is then driven byte by byte.
   task automatic model_cmd(input logic [7:0] b [6]);
      case (b[0])
         8'hC0, 8'hC2: begin
            for (int i = 0; i < 5; i++) m_par[i] = b[i+1];
            if (b[0] == 8'hC0) for (int i = 0; i < 5; i++) m_save[i] = b[i+1];
            for (int i = 0; i < 6; i++) exp_q.push_back(b[i]);
         end
         8'hC1: begin
            exp_q.push_back(8'hC0);
            for (int i = 0; i < 5; i++) exp_q.push_back(m_par[i]);
         end
         8'hC3: begin
            exp_q.push_back(8'hC3);
            exp_q.push_back(8'h32);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h14);
         end
         8'hC4: begin
`ifdef RF_CFG_SAVE_EN
            m_par = m_save;
`else
            m_par = DEF;
`endif
         end
         default: begin
         end
      endcase
   endtask

   task automatic run_cmd(input logic [7:0] b0, b1, b2, b3, b4, b5, input int gmin, input int gmax);
      logic [7:0] b [6];
      int         len;
      b   = '{b0, b1, b2, b3, b4, b5};
      len = (b0 == 8'hC0 || b0 == 8'hC2) ? 6 : 3;
      model_cmd(b);
      for (int i = 0; i < len; i++) begin
         if (i > 0) idle(int'($urandom_range(gmin, gmax)));
         send_byte(b[i]);
      end
      wait_aux_high("cmd_done_aux", 400);
      check("cmd_done_tx_valid", tx_valid, 0);
      check_params();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] c;
      logic [7:0] blk [6];
      int         cnt;
      do_reset();
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_aux", AUX_config_ctrl, 1);
      check_params();

      ready_mode = 0;
      run_cmd(8'hC0, 8'h12, 8'h34, 8'h1C, 8'h05, 8'h44, 0, 0);

      ready_mode = 1;
      run_cmd(8'hC1, 8'hC1, 8'hC1, 8'h00, 8'h00, 8'h00, 0, 0);

      for (int i = 0; i < 24; i++) begin
         ready_mode = int'($urandom_range(0, 2));
         case ($urandom_range(0, 4))
            0:       c = 8'hC0;
            1:       c = 8'hC2;
            2:       c = 8'hC1;
            3:       c = 8'hC3;
            default: c = 8'hC4;
         endcase
         if (c == 8'hC0 || c == 8'hC2)
            run_cmd(c, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 4);
         else
            run_cmd(c, c, c, 8'h00, 8'h00, 8'h00, 0, 4);
      end

      // Longest inter-byte gap that must still be accepted.
      ready_mode = 0;
      run_cmd(8'hC2, 8'h5A, 8'hA5, 8'h11, 8'h22, 8'h33, TO - 1, TO - 1);

      // Unknown first byte is ignored.
      send_byte(8'h55);
      idle(2);
      check("bad_first_aux", AUX_config_ctrl, 1);
      check_params();

      // Short command whose repeat byte differs is discarded.
      send_byte(8'hC1);
      send_byte(8'hC1);
      send_byte(8'hC2);
      check("bad_echo_aux", AUX_config_ctrl, 1);
      idle(3);
      check("bad_echo_tx_valid", tx_valid, 0);
      check_params();

      // Inter-byte timeout.
      send_byte(8'hC0);
      send_byte(8'h12);
      idle(TO - 2);
      check("timeout_not_yet_aux", AUX_config_ctrl, 0);
      idle(4);
      check("timeout_aux", AUX_config_ctrl, 1);
      check("timeout_tx_valid", tx_valid, 0);
      check_params();
      run_cmd(8'hC1, 8'hC1, 8'hC1, 8'h00, 8'h00, 8'h00, 0, 2);

      // sleep_mode dropping mid-collection, then bytes while not in sleep mode.
      send_byte(8'hC1);
      send_byte(8'hC1);
      sleep_mode = 1'b0;
      tick();
      check("sleep_discard_aux", AUX_config_ctrl, 1);
      for (int i = 0; i < 3; i++) begin
         send_byte(8'hC3);
         check("sleep_low_aux", AUX_config_ctrl, 1);
      end
      idle(4);
      check("sleep_low_tx_valid", tx_valid, 0);
      sleep_mode = 1'b1;
      tick();
      run_cmd(8'hC3, 8'hC3, 8'hC3, 8'h00, 8'h00, 8'h00, 0, 0);

      // Save/temporary/restore sequence with HOLD length measured on AUX.
      run_cmd(8'hC0, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 0, 1);
      run_cmd(8'hC2, 8'hBB, 8'h05, 8'h06, 8'h07, 8'h08, 0, 1);
      blk = '{8'hC4, 8'hC4, 8'hC4, 8'h00, 8'h00, 8'h00};
      model_cmd(blk);
      for (int i = 0; i < 3; i++) send_byte(8'hC4);
      cnt = 0;
      while (AUX_config_ctrl !== 1'b1 && cnt < int'(HOLD) + 20) begin
         tick();
         cnt++;
      end
      check("c4_aux_low_cycles", cnt, HOLD + 1);
      check_params();

      // Reset in the middle of a stalled response.
      ready_mode = 3;
      tick();
      blk = '{8'hC1, 8'hC1, 8'hC1, 8'h00, 8'h00, 8'h00};
      model_cmd(blk);
      for (int i = 0; i < 3; i++) send_byte(8'hC1);
      cnt = 0;
      while (tx_valid !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      check("midresp_tx_valid_seen", tx_valid, 1);
      idle(2);
      do_reset();
      check("midresp_rst_tx_valid", tx_valid, 0);
      check("midresp_rst_aux", AUX_config_ctrl, 1);
      check_params();
      ready_mode = 0;
      idle(5);
      check("midresp_after_tx_valid", tx_valid, 0);
      run_cmd(8'hC1, 8'hC1, 8'hC1, 8'h00, 8'h00, 8'h00, 0, 0);

      idle(3);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rf_config_controller.md
RF_CONFIG_CONTROLLER -- requirements
Module: rf_config_controller

Interface
REQ-001 SHALL have parameter DEFAULT_ADDH, 8'h00, power-on high address byte.
REQ-002 SHALL have parameter DEFAULT_ADDL, 8'h00, power-on low address byte.
REQ-003 SHALL have parameter DEFAULT_SPED, 8'h1A, power-on air/UART rate byte.
REQ-004 SHALL have parameter DEFAULT_CHAN, 8'h17, power-on channel byte.
REQ-005 SHALL have parameter DEFAULT_OPTION, 8'h44, power-on option byte.
REQ-006 SHALL have parameter VERSION_ID, 8'h32, version byte returned by C3 command.
REQ-007 SHALL have parameter BYTE_TIMEOUT, 15000, max idle cycles between command bytes.
REQ-008 SHALL have parameter RESET_HOLD, 10000, AUX-low cycles after C4 command.
REQ-009 internal_clk  input  1  clock, all logic on rising edge.
REQ-010 rst_n  input  1  reset, asynchronous, active-low.
REQ-011 sleep_mode  input  1  high when synchronized mode == 3 (configuration allowed).
REQ-012 rx_valid  input  1  one-cycle strobe, byte from MCU UART receiver.
REQ-013 rx_data  input  8  received byte, valid with rx_valid.
REQ-014 tx_valid  output  1  response byte available to MCU UART transmitter.
REQ-015 tx_data  output  8  response byte.
REQ-016 tx_ready  input  1  transmitter accepts byte when tx_valid & tx_ready.
REQ-017 AUX_config_ctrl  output  1  high = idle; low = command in progress.
REQ-018 addh, addl, sped, chan, option  output  8 each  working parameter registers driving the RF datapath.

Function
REQ-019 FSM states SHALL be IDLE, COLLECT, EXEC, RESPOND, HOLD.
REQ-020 IDLE: rx_valid & sleep_mode SHALL store byte 0, go COLLECT, drop AUX_config_ctrl next cycle; rx_valid with sleep_mode low SHALL be ignored.
REQ-021 COLLECT SHALL store bytes until command length met: 6 for first byte C0/C2, 3 for C1/C3/C4.
REQ-022 First byte not in {C0,C1,C2,C3,C4} SHALL return to IDLE, no response, no parameter change.
REQ-023 C1/C3/C4: bytes 1-2 SHALL equal byte 0, else discard and return to IDLE.
REQ-024 Gap counter SHALL reset on each accepted byte; reaching BYTE_TIMEOUT in COLLECT SHALL discard and return to IDLE.
REQ-025 sleep_mode falling in COLLECT SHALL discard and return to IDLE the next cycle.
REQ-026 Final byte accepted at edge N SHALL enter EXEC; EXEC SHALL last exactly one cycle, parameter writes visible after edge N+1.
REQ-027 C0/C2 SHALL write bytes 1..5 to addh, addl, sped, chan, option; response = 6 bytes: command byte then new values.
REQ-028 C1 SHALL respond 6 bytes: C0, addh, addl, sped, chan, option.
REQ-029 C3 SHALL respond 4 bytes: C3, VERSION_ID, 00, 14.
REQ-030 C4 SHALL restore parameters (per REQ-040/041), no response, enter HOLD for RESET_HOLD cycles, then IDLE.
REQ-031 RESPOND: tx_valid SHALL assert the cycle after EXEC; tx_data stable until tx_valid & tx_ready; next byte presented the following cycle; tx_valid deasserts after last handshake.
REQ-032 RESPOND/HOLD SHALL complete regardless of sleep_mode; rx_valid in EXEC/RESPOND/HOLD SHALL be dropped.
REQ-033 AUX_config_ctrl SHALL be low from the cycle after the first byte until the cycle after the last response handshake or HOLD end; it SHALL return high on any discard.
REQ-034 Parameter outputs SHALL change only in EXEC.

Reset
REQ-035 rst_n low SHALL force IDLE, tx_valid=0, tx_data=0, AUX_config_ctrl=1, counters=0.
REQ-036 rst_n low SHALL load addh..option with DEFAULT_* values (and shadow bank, if present).
REQ-037 Reset mid-command or mid-response SHALL abandon it without residual output on release.

Configuration
REQ-038 Macro RF_CFG_SAVE_EN SHALL select a saved-parameter shadow bank.
REQ-039 Defined: C0 SHALL write working and shadow; C2 working only.
REQ-040 Defined: C4 SHALL copy shadow to working.
REQ-041 Undefined: no shadow; C0 and C2 identical (working only, echo keeps own command byte); C4 loads DEFAULT_* values.

Verification
REQ-042 sleep_mode=1, send C0 12 34 1C 05 44, tx_ready=1 -> params 12/34/1C/05/44, response C0 12 34 1C 05 44, AUX low throughout.
REQ-043 Send C1 C1 C1 with tx_ready toggling every other cycle -> six bytes C0 + params, each held until handshake, tx_valid low after sixth.
REQ-044 Send C0 12 then no byte for BYTE_TIMEOUT cycles -> IDLE, AUX high, params unchanged, no tx_valid.
REQ-045 With RF_CFG_SAVE_EN: C0 AA..., C2 BB..., C4 C4 C4 -> addh=AA after HOLD, AUX low exactly RESET_HOLD cycles; without macro -> addh=00.
REQ-046 Send C1 C1 then sleep_mode=0 -> discard, AUX high next cycle; send C3 C3 C3 with sleep_mode=0 -> ignored; rst_n pulse mid-response -> tx_valid=0, defaults restored.
